uart_receiver: RTL and testbench

Serial-to-parallel UART receiver (8N1, LSB first) feeding the tester memory. It sits between the `uart_rx` board pin and the memory block's `in_uart` / `in_uart_en` inputs. Each correctly framed byte is delivered as one 8-bit word with a single-cycle strobe. Start-bit glitches are rejected, and bad stop bits are flagged rather than forwarded.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_receiver.sv | 121 ++++++++++++
 tb/tb_uart_receiver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and baud divisor helper.
// Also consumed by the transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_CPB   = 8;

  // Clocks per bit, rounded to nearest.
  function automatic int cpb(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line followed by a three-sample majority window.
// maj_o votes over rx_s from the previous two cycles and the current one.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic maj_o
);

  logic       meta_q;
  logic       rx_s_q;
  logic [1:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      hist_q <= 2'b11;
    end else begin
      meta_q <= rx_i;
      rx_s_q <= meta_q;
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign rx_s_o = rx_s_q;
  assign maj_o  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, glitch rejection on the start bit,
// one-cycle strobes for a good byte or a framing error.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = cpb(CLK_HZ, BAUD)
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_rx,
  output logic [UART_DATA_BITS-1:0] out_data,
  output logic                      out_data_en,
  output logic                      out_frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < UART_MIN_CPB) begin : g_cpb_check
    $error("uart_receiver: CLKS_PER_BIT must be at least %0d", UART_MIN_CPB);
  end

  logic rx_s;
  logic maj;

  uart_rx_sync u_sync (
    .clk_i (in_clk),
    .rst_i (in_rst),
    .rx_i  (in_rx),
    .rx_s_o(rx_s),
    .maj_o (maj)
  );

  uart_rx_state_t            state_q;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic [BW-1:0]             bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      data_en_q;
  logic                      frame_err_q;
  logic                      decide;

  always_comb begin
    cnt_d = '0;
    if (state_q == START || state_q == DATA || state_q == STOP) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  // The vote window closes on the HALF+1 sample, so every decision lands there.
  assign decide = (cnt_q == CNT_DEC);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= cnt_d;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (decide) begin
            if (maj) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shift_q   <= {maj, shift_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + BW'(1);
            if (bit_idx_q == IDX_LAST) state_q <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (maj) begin
              data_q    <= shift_q;
              data_en_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data      = data_q;
  assign out_data_en   = data_en_q;
  assign out_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks per bit: frame-level expectation model checked every cycle,
// plus literal checks on latency, spacing and received bytes.
module tb_uart_receiver;

  localparam int CPB     = 16;
  localparam int LATENCY = 157;  // pin falls in cycle n0 -> D = n0+2 -> strobe at D+155

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_rx  = 1'b1;
  logic [7:0] out_data;
  logic       out_data_en;
  logic       out_frame_err;

  uart_receiver #(
    .CLK_HZ(1_600_000),
    .BAUD  (100_000)
  ) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_rx        (in_rx),
    .out_data     (out_data),
    .out_data_en  (out_data_en),
    .out_frame_err(out_frame_err)
  );

  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  // Expectation model: cycle-indexed events derived from the frame timing rules.
  bit         exp_en   [int];
  bit         exp_fe   [int];
  logic [7:0] exp_byte [int];
  bit         rst_cyc  [int];
  logic [7:0] model_data = 8'h00;
  bit         chk_on = 1'b0;
  bit         e_en;
  bit         e_fe;

  int         q_en[$];
  int         q_fe[$];
  logic [7:0] q_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge in_clk) begin
    if (chk_on) begin
      if (rst_cyc.exists(cyc)) model_data = 8'h00;
      e_en = exp_en.exists(cyc);
      e_fe = exp_fe.exists(cyc);
      if (e_en) model_data = exp_byte[cyc];
      n_checks++;
      if (out_data_en !== e_en || out_frame_err !== e_fe || out_data !== model_data) begin
        n_errors++;
        $display("FAIL cycle_cmp @%0d: en=%b ferr=%b data=%h, expected en=%b ferr=%b data=%h",
                 cyc, out_data_en, out_frame_err, out_data, e_en, e_fe, model_data);
      end
      if (out_data_en === 1'b1) begin
        q_en.push_back(cyc);
        q_dat.push_back(out_data);
      end
      if (out_frame_err === 1'b1) q_fe.push_back(cyc);
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic drive_bits(input logic [9:0] bits, input int spike_j, input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      in_rx = bits[j / CPB] ^ (j == spike_j);
      step();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_j,
                            output int n0);
    n0 = cyc;
    if (stop_bit) begin
      exp_en[n0 + LATENCY]   = 1'b1;
      exp_byte[n0 + LATENCY] = b;
    end else begin
      exp_fe[n0 + LATENCY] = 1'b1;
    end
    drive_bits({stop_bit, b, 1'b0}, spike_j, 10 * CPB);
  endtask

  task automatic pulse_reset();
    in_rst = 1'b1;
    in_rx  = 1'b1;
    rst_cyc[cyc + 1] = 1'b1;
    repeat (3) step();
    check("midrst_data_zero", {24'h0, out_data}, 32'h0);
    check("midrst_en_zero", {31'h0, out_data_en}, 32'h0);
    in_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  int n0;
  int n1;

  initial begin
    in_rst = 1'b1;
    in_rx  = 1'b1;
    repeat (3) step();
    check("rst_data", {24'h0, out_data}, 32'h0);
    check("rst_en", {31'h0, out_data_en}, 32'h0);
    check("rst_ferr", {31'h0, out_frame_err}, 32'h0);
    in_rst = 1'b0;
    chk_on = 1'b1;

    idle(500);
    check("idle_no_strobe", q_en.size() + q_fe.size(), 0);

    send_frame(8'hA5, 1'b1, -1, n0);
    idle(20);
    check("a5_count", q_en.size(), 1);
    check("a5_latency", q_en[0] - n0, 157);
    check("a5_data", {24'h0, q_dat[0]}, 32'hA5);
    check("a5_no_ferr", q_fe.size(), 0);

    send_frame(8'h00, 1'b1, -1, n0);
    send_frame(8'hFF, 1'b1, -1, n1);
    idle(20);
    check("b2b_count", q_en.size(), 3);
    check("b2b_gap", q_en[2] - q_en[1], 160);
    check("b2b_first", {24'h0, q_dat[1]}, 32'h00);
    check("b2b_second", {24'h0, q_dat[2]}, 32'hFF);

    in_rx = 1'b0;
    repeat (3) step();
    idle(60);
    check("glitch_no_strobe", q_en.size() + q_fe.size(), 3);
    check("glitch_idle", {29'h0, dut.state_q}, {29'h0, uart_pkg::IDLE});
    send_frame(8'h3C, 1'b1, -1, n0);
    idle(20);
    check("after_glitch_data", {24'h0, q_dat[3]}, 32'h3C);

    send_frame(8'h55, 1'b0, -1, n0);
    in_rx = 1'b0;
    repeat (40) step();
    idle(20);
    check("ferr_count", q_fe.size(), 1);
    check("ferr_latency", q_fe[0] - n0, 157);
    check("ferr_data_held", {24'h0, out_data}, 32'h3C);
    check("ferr_no_strobe", q_en.size(), 4);
    send_frame(8'h12, 1'b1, -1, n0);
    idle(20);
    check("after_ferr_data", {24'h0, q_dat[4]}, 32'h12);

    drive_bits({1'b1, 8'h5A, 1'b0}, -1, 5 * CPB + CPB / 2);
    pulse_reset();
    idle(40);
    check("midrst_no_strobe", q_en.size() + q_fe.size(), 6);
    send_frame(8'hC3, 1'b1, -1, n0);
    idle(20);
    check("after_rst_data", {24'h0, q_dat[5]}, 32'hC3);

    // Line offset 1 + 4*16 + 8 is the centre sample of data bit 3.
    send_frame(8'h00, 1'b1, 73, n0);
    idle(20);
    check("spike_count", q_en.size(), 7);
    check("spike_data", {24'h0, q_dat[6]}, 32'h00);
    check("spike_out", {24'h0, out_data}, 32'h00);

    idle(100);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
